// File: rtl/trg_link_pkg.sv
// trg_link_pkg -- shared definitions for the trigger link (receive and transmit side).
//   K-character codes used in the frame header byte, the per-byte K-flag
//   patterns, the link state encoding and the frame-flag bundle.
package trg_link_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;   // normal frame
    localparam logic [7:0] K28_1 = 8'h3C;   // overflow
    localparam logic [7:0] K28_3 = 8'h7C;   // BC0
    localparam logic [7:0] K28_7 = 8'hFC;   // resync

    localparam logic [1:0] ISK_HDR  = 2'b01; // header word: low byte is a K char
    localparam logic [1:0] ISK_DATA = 2'b00; // payload word: no K chars

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SYNCING  = 2'd1,
        ST_LOCKED   = 2'd2
    } link_state_t;

    typedef struct packed {
        logic overflow;
        logic bc0;
        logic resync;
    } frame_flags_t;

endpackage

// File: rtl/trg_link_hdr_decode.sv
// trg_link_hdr_decode -- purely combinational frame-header classifier.
//   k_char   in  8  low byte of the candidate W0 word
//   isk      in  2  per-byte K flags of that word
//   hdr_good out 1  word is a valid frame header
//   flags    out 3  overflow / bc0 / resync decoded from the K char (0 unless hdr_good)
module trg_link_hdr_decode
    import trg_link_pkg::*;
(
    input  logic [7:0]   k_char,
    input  logic [1:0]   isk,
    output logic         hdr_good,
    output frame_flags_t flags
);

    always_comb begin
        hdr_good = 1'b0;
        flags    = '0;
        if (isk == ISK_HDR) begin
            case (k_char)
                K28_5: hdr_good = 1'b1;
                K28_1: begin hdr_good = 1'b1; flags.overflow = 1'b1; end
                K28_3: begin hdr_good = 1'b1; flags.bc0      = 1'b1; end
                K28_7: begin hdr_good = 1'b1; flags.resync   = 1'b1; end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/trg_link_rx.sv
// trg_link_rx -- trigger link receiver: frame alignment, lock tracking and
// payload reassembly of 4-word (one BX) frames from an 8b10b MGT.
//   clk_160     in   1  receive clock, everything on its rising edge
//   reset       in   1  synchronous, active-high
//   rx_data     in  16  decoded word, low byte first
//   rx_isk      in   2  per-byte K flags (bit0 -> rx_data[7:0])
//   rx_ready    in   1  MGT ready; low forces UNLOCKED and clears counters
//   gem_data    out 56  reassembled payload, held between valid_o strobes
//   overflow_o, bc0_o, resync_o out 1  header flags of the last valid frame
//   valid_o     out  1  strobe: new error-free frame
//   locked_o    out  1  link is LOCKED
//   frame_err_o out  1  strobe: one per errored frame
//   err_cnt     out 16  saturating frame-error count
// Build option: define TRG_LINK_RX_ERR_CNT_EN to build the error counter;
// otherwise err_cnt is tied to zero.
module trg_link_rx
    import trg_link_pkg::*;
#(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3
) (
    input  logic        clk_160,
    input  logic        reset,
    input  logic [15:0] rx_data,
    input  logic [1:0]  rx_isk,
    input  logic        rx_ready,
    output logic [55:0] gem_data,
    output logic        overflow_o,
    output logic        bc0_o,
    output logic        resync_o,
    output logic        valid_o,
    output logic        locked_o,
    output logic        frame_err_o,
    output logic [15:0] err_cnt
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);

    link_state_t       state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [BAD_W-1:0]  bad_q, bad_d;
    logic              hdr_lock_q, hdr_lock_d; // this frame's W0 arrived while LOCKED
    logic              frm_err_q, frm_err_d;   // this frame already reported an error
    logic              vld_d, ferr_d;
    logic              vld_p1, ferr_p1;
    logic              hdr_good, word_err;
    frame_flags_t      hdr_flags, flags_p0;
    logic [7:0]        w0_hi_p0;
    logic [15:0]       w1_p0, w2_p0;

    trg_link_hdr_decode u_hdr_decode (
        .k_char   (rx_data[7:0]),
        .isk      (rx_isk),
        .hdr_good (hdr_good),
        .flags    (hdr_flags)
    );

    // W0 must be a header; W1..W3 must carry no K chars (a stray header counts as an error).
    assign word_err = (idx_q == 2'd0) ? !hdr_good : (rx_isk != ISK_DATA);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q + 2'd1;
        good_d     = good_q;
        bad_d      = bad_q;
        hdr_lock_d = hdr_lock_q;
        frm_err_d  = frm_err_q;
        vld_d      = 1'b0;
        ferr_d     = 1'b0;
        if (!rx_ready) begin
            state_d    = ST_UNLOCKED;
            idx_d      = 2'd0;
            good_d     = '0;
            bad_d      = '0;
            hdr_lock_d = 1'b0;
            frm_err_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_UNLOCKED: begin
                    idx_d = 2'd0;
                    if (hdr_good) begin
                        state_d = ST_SYNCING;
                        idx_d   = 2'd1;
                        good_d  = GOOD_W'(1);
                    end
                end
                ST_SYNCING: begin
                    if (word_err) begin
                        state_d = ST_UNLOCKED;
                        idx_d   = 2'd0;
                        good_d  = '0;
                        ferr_d  = 1'b1;
                    end else if (idx_q == 2'd0) begin
                        good_d = good_q + GOOD_W'(1);
                        if (good_d == GOOD_W'(LOCK_COUNT)) begin
                            // The frame whose header completed the lock is not delivered.
                            state_d    = ST_LOCKED;
                            bad_d      = '0;
                            hdr_lock_d = 1'b0;
                            frm_err_d  = 1'b0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (idx_q == 2'd0) begin
                        hdr_lock_d = 1'b1;
                        frm_err_d  = 1'b0;
                    end
                    if (word_err && (idx_q == 2'd0 || !frm_err_q)) begin
                        ferr_d    = 1'b1;
                        frm_err_d = 1'b1;
                        bad_d     = bad_q + BAD_W'(1);
                        if (bad_d == BAD_W'(UNLOCK_COUNT)) begin
                            state_d    = ST_UNLOCKED;
                            idx_d      = 2'd0;
                            good_d     = '0;
                            bad_d      = '0;
                            hdr_lock_d = 1'b0;
                        end
                    end else if (idx_q == 2'd3 && !word_err && !frm_err_q) begin
                        bad_d = '0;
                        vld_d = hdr_lock_q;
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                    idx_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_160) begin
        if (reset) begin
            state_q    <= ST_UNLOCKED;
            idx_q      <= 2'd0;
            good_q     <= '0;
            bad_q      <= '0;
            hdr_lock_q <= 1'b0;
            frm_err_q  <= 1'b0;
            vld_p1     <= 1'b0;
            ferr_p1    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            hdr_lock_q <= hdr_lock_d;
            frm_err_q  <= frm_err_d;
            vld_p1     <= vld_d;
            ferr_p1    <= ferr_d;
        end
    end

    // Stage p0: capture W0..W2 of the frame in flight.
    always_ff @(posedge clk_160) begin
        if (idx_q == 2'd0) begin
            w0_hi_p0 <= rx_data[15:8];
            flags_p0 <= hdr_flags;
        end
        if (idx_q == 2'd1) w1_p0 <= rx_data;
        if (idx_q == 2'd2) w2_p0 <= rx_data;
    end

    // Stage p1: publish the frame together with W3, only on a valid strobe.
    always_ff @(posedge clk_160) begin
        if (reset) begin
            gem_data                       <= '0;
            {overflow_o, bc0_o, resync_o}  <= '0;
        end else if (vld_d) begin
            gem_data                       <= {w0_hi_p0, w1_p0, w2_p0, rx_data};
            {overflow_o, bc0_o, resync_o}  <= flags_p0;
        end
    end

    assign valid_o     = vld_p1;
    assign frame_err_o = ferr_p1;
    assign locked_o    = (state_q == ST_LOCKED);

`ifdef TRG_LINK_RX_ERR_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] err_cnt_q;

    always_ff @(posedge clk_160) begin
        if (reset || !rx_ready) begin
            err_cnt_q <= '0;
        end else if (ferr_d) begin
            err_cnt_q <= sat_inc16(err_cnt_q);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_trg_link_rx.sv
// tb_trg_link_rx -- scenario and randomized bench for trg_link_rx with a
// frame-level reference model.
module tb_trg_link_rx;

    localparam int LOCK_COUNT   = 4;
    localparam int UNLOCK_COUNT = 3;
`ifdef TRG_LINK_RX_ERR_CNT_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif
    localparam int S_UNL = 0;
    localparam int S_SYN = 1;
    localparam int S_LCK = 2;

    logic        clk_160 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] rx_data = '0;
    logic [1:0]  rx_isk = '0;
    logic        rx_ready = 1'b0;
    logic [55:0] gem_data;
    logic        overflow_o, bc0_o, resync_o, valid_o, locked_o, frame_err_o;
    logic [15:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #3 clk_160 = ~clk_160;

    trg_link_rx #(.LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT)) dut (
        .clk_160     (clk_160),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_isk      (rx_isk),
        .rx_ready    (rx_ready),
        .gem_data    (gem_data),
        .overflow_o  (overflow_o),
        .bc0_o       (bc0_o),
        .resync_o    (resync_o),
        .valid_o     (valid_o),
        .locked_o    (locked_o),
        .frame_err_o (frame_err_o),
        .err_cnt     (err_cnt)
    );

    // Reference model: link status plus the words of the frame in flight.
    int          m_state, m_pos, m_good, m_bad;
    bit          m_hdr_locked, m_frame_bad;
    logic [15:0] m_words [4];
    logic [55:0] e_gem;
    bit          e_ovf, e_bc0, e_rsy, e_valid, e_locked, e_ferr;
    logic [15:0] e_errcnt;

    function automatic bit is_hdr(input logic [15:0] d, input logic [1:0] k);
        return (k == 2'b01) && (d[7:0] == 8'hBC || d[7:0] == 8'h3C ||
                                d[7:0] == 8'h7C || d[7:0] == 8'hFC);
    endfunction

    function automatic logic [2:0] kflags(input logic [7:0] kc);
        if (kc == 8'h3C) return 3'b100;
        if (kc == 8'h7C) return 3'b010;
        if (kc == 8'hFC) return 3'b001;
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_state = S_UNL; m_pos = 0; m_good = 0; m_bad = 0;
        m_hdr_locked = 1'b0; m_frame_bad = 1'b0;
        e_gem = '0; e_ovf = 0; e_bc0 = 0; e_rsy = 0;
        e_valid = 0; e_locked = 0; e_ferr = 0; e_errcnt = '0;
    endtask

    task automatic model_step(input logic [15:0] d, input logic [1:0] k, input bit rdy);
        bit hdr;
        bit bad_word;
        int p;
        hdr = is_hdr(d, k);
        e_valid = 0;
        e_ferr  = 0;
        if (!rdy) begin
            m_state = S_UNL; m_pos = 0; m_good = 0; m_bad = 0;
            m_frame_bad = 0; m_hdr_locked = 0; e_errcnt = '0;
        end else if (m_state == S_UNL) begin
            if (hdr) begin m_state = S_SYN; m_good = 1; m_pos = 1; end
        end else begin
            p = m_pos;
            m_pos = (m_pos + 1) % 4;
            bad_word = (p == 0) ? !hdr : (k != 2'b00);
            if (p == 0) begin m_frame_bad = 0; m_hdr_locked = (m_state == S_LCK); end
            m_words[p] = d;
            if (m_state == S_SYN) begin
                if (bad_word) begin
                    e_ferr = 1; m_state = S_UNL; m_good = 0; m_pos = 0;
                end else if (p == 0) begin
                    m_good++;
                    if (m_good >= LOCK_COUNT) begin m_state = S_LCK; m_bad = 0; end
                end
            end else if (bad_word) begin
                if (!m_frame_bad) begin
                    e_ferr = 1; m_frame_bad = 1; m_bad++;
                    if (m_bad >= UNLOCK_COUNT) begin
                        m_state = S_UNL; m_bad = 0; m_good = 0; m_pos = 0;
                    end
                end
            end else if (p == 3 && !m_frame_bad) begin
                m_bad = 0;
                if (m_hdr_locked) begin
                    e_valid = 1;
                    e_gem = {m_words[0][15:8], m_words[1], m_words[2], m_words[3]};
                    {e_ovf, e_bc0, e_rsy} = kflags(m_words[0][7:0]);
                end
            end
        end
        e_locked = (m_state == S_LCK);
        if (ERR_ON && e_ferr && e_errcnt != 16'hFFFF) e_errcnt = e_errcnt + 16'd1;
    endtask

    task automatic send_word(input logic [15:0] d, input logic [1:0] k, input bit rdy);
        rx_data = d; rx_isk = k; rx_ready = rdy; reset = 1'b0;
        model_step(d, k, rdy);
        @(posedge clk_160); #1;
    endtask

    task automatic send_frame(input logic [7:0] kc, input logic [7:0] hi,
                              input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3);
        send_word({hi, kc}, 2'b01, 1'b1);
        send_word(w1, 2'b00, 1'b1);
        send_word(w2, 2'b00, 1'b1);
        send_word(w3, 2'b00, 1'b1);
    endtask

    task automatic test_reset();
        rx_data = 16'h12BC; rx_isk = 2'b01; rx_ready = 1'b1; reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_160);
        #1;
        n_checks++;
        if ({gem_data, overflow_o, bc0_o, resync_o, valid_o, frame_err_o, err_cnt} !== 78'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=0", {gem_data, overflow_o, bc0_o, resync_o, valid_o, frame_err_o, err_cnt});
        end
        n_checks++;
        if (locked_o !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%b exp=0", locked_o); end
        reset = 1'b0;
    endtask

    task automatic test_lock();
        for (int f = 0; f < 4; f++) begin
            send_word(16'h12BC, 2'b01, 1'b1);
            n_checks++;
            if (locked_o !== (f == 3)) begin
                n_fail++; $display("FAIL lock_after_hdr%0d got=%b exp=%b", f + 1, locked_o, (f == 3));
            end
            send_word(16'h3456, 2'b00, 1'b1);
            send_word(16'h789A, 2'b00, 1'b1);
            send_word(16'hBCDE, 2'b00, 1'b1);
            n_checks++;
            if (valid_o !== 1'b0) begin n_fail++; $display("FAIL lock_no_valid%0d got=%b exp=0", f + 1, valid_o); end
        end
        send_frame(8'hBC, 8'h12, 16'h3456, 16'h789A, 16'hBCDE);
        n_checks++;
        if (valid_o !== 1'b1) begin n_fail++; $display("FAIL lock_first_valid got=%b exp=1", valid_o); end
        n_checks++;
        if (gem_data !== 56'h123456789ABCDE) begin
            n_fail++; $display("FAIL lock_gem_data got=%h exp=123456789abcde", gem_data);
        end
        n_checks++;
        if ({overflow_o, bc0_o, resync_o} !== 3'b000) begin
            n_fail++; $display("FAIL lock_flags got=%b exp=000", {overflow_o, bc0_o, resync_o});
        end
    endtask

    task automatic test_flags();
        logic [7:0]  kcs [5];
        logic [2:0]  fl  [5];
        logic [7:0]  hi;
        logic [15:0] w1, w2, w3;
        kcs = '{8'h3C, 8'h7C, 8'hBC, 8'hFC, 8'hBC};
        fl  = '{3'b100, 3'b010, 3'b000, 3'b001, 3'b000};
        for (int i = 0; i < 5; i++) begin
            hi = 8'($urandom); w1 = 16'($urandom); w2 = 16'($urandom); w3 = 16'($urandom);
            send_frame(kcs[i], hi, w1, w2, w3);
            n_checks++;
            if (valid_o !== 1'b1) begin n_fail++; $display("FAIL flags_valid%0d got=%b exp=1", i, valid_o); end
            n_checks++;
            if (gem_data !== {hi, w1, w2, w3}) begin
                n_fail++; $display("FAIL flags_gem%0d got=%h exp=%h", i, gem_data, {hi, w1, w2, w3});
            end
            n_checks++;
            if ({overflow_o, bc0_o, resync_o} !== fl[i]) begin
                n_fail++; $display("FAIL flags_k%h got=%b exp=%b", kcs[i], {overflow_o, bc0_o, resync_o}, fl[i]);
            end
        end
    endtask

    task automatic test_err_frame();
        logic [55:0] held;
        held = e_gem;
        send_word(16'h55BC, 2'b01, 1'b1);
        send_word(16'h1111, 2'b00, 1'b1);
        send_word(16'h2222, 2'b10, 1'b1);
        n_checks++;
        if (frame_err_o !== 1'b1) begin n_fail++; $display("FAIL err_strobe got=%b exp=1", frame_err_o); end
        send_word(16'h3333, 2'b00, 1'b1);
        n_checks++;
        if ({valid_o, frame_err_o, locked_o} !== 3'b001) begin
            n_fail++; $display("FAIL err_valid_err_lock got=%b exp=001", {valid_o, frame_err_o, locked_o});
        end
        n_checks++;
        if (gem_data !== held) begin n_fail++; $display("FAIL err_gem_held got=%h exp=%h", gem_data, held); end
        n_checks++;
        if (err_cnt !== (ERR_ON ? 16'd1 : 16'd0)) begin
            n_fail++; $display("FAIL err_cnt_one got=%h exp=%h", err_cnt, (ERR_ON ? 16'd1 : 16'd0));
        end
        send_frame(8'hBC, 8'hA5, 16'h0102, 16'h0304, 16'h0506);
        n_checks++;
        if (valid_o !== 1'b1) begin n_fail++; $display("FAIL err_recover_valid got=%b exp=1", valid_o); end
        // Two more bad frames must not unlock if the good frame cleared bad_cnt.
        for (int f = 0; f < 2; f++) begin
            send_word(16'h00BC, 2'b00, 1'b1);
            send_word(16'h0000, 2'b00, 1'b1);
            send_word(16'h0000, 2'b00, 1'b1);
            send_word(16'h0000, 2'b00, 1'b1);
        end
        n_checks++;
        if (locked_o !== 1'b1) begin n_fail++; $display("FAIL err_badcnt_cleared got=%b exp=1", locked_o); end
        send_frame(8'hBC, 8'h01, 16'h0203, 16'h0405, 16'h0607);
    endtask

    task automatic test_unlock();
        for (int f = 0; f < 3; f++) begin
            send_word(16'h00BC, 2'b00, 1'b1);
            n_checks++;
            if ({locked_o, frame_err_o} !== {(f != 2), 1'b1}) begin
                n_fail++; $display("FAIL unlock_bad%0d got=%b exp=%b", f + 1, {locked_o, frame_err_o}, {(f != 2), 1'b1});
            end
            send_word(16'h0000, 2'b00, 1'b1);
            send_word(16'h0000, 2'b00, 1'b1);
            send_word(16'h0000, 2'b00, 1'b1);
        end
        for (int f = 0; f < 4; f++) begin
            send_word(16'h77BC, 2'b01, 1'b1);
            n_checks++;
            if (locked_o !== (f == 3)) begin
                n_fail++; $display("FAIL relock_hdr%0d got=%b exp=%b", f + 1, locked_o, (f == 3));
            end
            send_word(16'h1234, 2'b00, 1'b1);
            send_word(16'h5678, 2'b00, 1'b1);
            send_word(16'h9ABC, 2'b00, 1'b1);
        end
        n_checks++;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL relock_no_valid got=%b exp=0", valid_o); end
        send_frame(8'hBC, 8'h77, 16'h1234, 16'h5678, 16'h9ABC);
        n_checks++;
        if (valid_o !== 1'b1) begin n_fail++; $display("FAIL relock_valid got=%b exp=1", valid_o); end
    endtask

    task automatic test_rx_ready();
        send_word(16'h99BC, 2'b01, 1'b1);
        send_word(16'hAAAA, 2'b00, 1'b1);
        send_word(16'hBBBB, 2'b00, 1'b0);
        n_checks++;
        if ({locked_o, valid_o} !== 2'b00) begin
            n_fail++; $display("FAIL rdy_drop got=%b exp=00", {locked_o, valid_o});
        end
        send_word(16'hCCCC, 2'b00, 1'b0);
        send_frame(8'hBC, 8'h99, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        n_checks++;
        if ({locked_o, valid_o} !== 2'b00) begin
            n_fail++; $display("FAIL rdy_resync got=%b exp=00", {locked_o, valid_o});
        end
`ifdef TRG_LINK_RX_ERR_CNT_EN
        force dut.err_cnt_q = 16'hFFFF;
        #1;
        release dut.err_cnt_q;
        e_errcnt = 16'hFFFF;
`endif
        send_word(16'h00BC, 2'b00, 1'b1);
        n_checks++;
        if (frame_err_o !== 1'b1) begin n_fail++; $display("FAIL rdy_sync_err got=%b exp=1", frame_err_o); end
        n_checks++;
        if (err_cnt !== (ERR_ON ? 16'hFFFF : 16'h0000)) begin
            n_fail++; $display("FAIL err_cnt_sat got=%h exp=%h", err_cnt, (ERR_ON ? 16'hFFFF : 16'h0000));
        end
    endtask

    task automatic test_reset_mid();
        for (int f = 0; f < 5; f++) send_frame(8'hBC, 8'h42, 16'h4242, 16'h4343, 16'h4444);
        n_checks++;
        if ({locked_o, valid_o} !== 2'b11) begin
            n_fail++; $display("FAIL rstmid_prelock got=%b exp=11", {locked_o, valid_o});
        end
        send_word(16'h42BC, 2'b01, 1'b1);
        rx_data = 16'h4242; rx_isk = 2'b00; rx_ready = 1'b1; reset = 1'b1;
        model_reset();
        @(posedge clk_160); #1;
        reset = 1'b0;
        n_checks++;
        if ({gem_data, overflow_o, bc0_o, resync_o, valid_o, locked_o, frame_err_o, err_cnt} !== 78'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got=%h exp=0", {gem_data, overflow_o, bc0_o, resync_o, valid_o, locked_o, frame_err_o, err_cnt});
        end
        send_word(16'h4343, 2'b00, 1'b1);
        send_word(16'h4444, 2'b00, 1'b1);
        n_checks++;
        if ({locked_o, valid_o} !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_discard got=%b exp=00", {locked_o, valid_o});
        end
        for (int f = 0; f < 4; f++) begin
            send_word(16'h42BC, 2'b01, 1'b1);
            n_checks++;
            if (locked_o !== (f == 3)) begin
                n_fail++; $display("FAIL rstmid_relock%0d got=%b exp=%b", f + 1, locked_o, (f == 3));
            end
            send_word(16'h4242, 2'b00, 1'b1);
            send_word(16'h4343, 2'b00, 1'b1);
            send_word(16'h4444, 2'b00, 1'b1);
        end
    endtask

    task automatic test_random();
        logic [7:0]  kcs [4];
        logic [15:0] d;
        logic [1:0]  k;
        bit          rdy;
        int          kind, badw;
        logic [77:0] got, exp;
        kcs = '{8'hBC, 8'h3C, 8'h7C, 8'hFC};
        rx_data = '0; rx_isk = '0; rx_ready = 1'b1; reset = 1'b1;
        model_reset();
        @(posedge clk_160); #1;
        for (int f = 0; f < 300; f++) begin
            kind = int'($urandom_range(0, 19));
            badw = int'($urandom_range(0, 3));
            for (int w = 0; w < 4; w++) begin
                d   = 16'($urandom);
                k   = 2'b00;
                rdy = 1'b1;
                if (w == 0) begin
                    d[7:0] = kcs[$urandom_range(0, 3)];
                    k = 2'b01;
                end
                if (kind == 0 && w == badw) rdy = 1'b0;
                if (kind == 1 && w == 0) k = 2'($urandom_range(2, 3));
                if (kind == 2 && w == 0) d[7:0] = 8'h1C;
                if (kind == 3 && w != 0 && w == badw) k = 2'($urandom_range(1, 3));
                send_word(d, k, rdy);
                got = {gem_data, overflow_o, bc0_o, resync_o, valid_o, locked_o, frame_err_o, err_cnt};
                exp = {e_gem, e_ovf, e_bc0, e_rsy, e_valid, e_locked, e_ferr, e_errcnt};
                n_checks++;
                if (got !== exp) begin
                    n_fail++; $display("FAIL rand_f%0d_w%0d got=%h exp=%h", f, w, got, exp);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_flags();
        test_err_frame();
        test_unlock();
        test_rx_ready();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trg_link_rx.md
TRG_LINK_RX -- requirements
Module: trg_link_rx

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4: consecutive good frame headers needed to reach LOCKED.
REQ-002 SHALL have parameter UNLOCK_COUNT, default 3: consecutive bad frames that drop LOCKED.
REQ-003 SHALL have port clk_160  input  1  the single 160 MHz receive clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  16  decoded 8b10b word from the MGT, low byte first.
REQ-006 SHALL have port rx_isk  input  2  per-byte K flag; bit0 belongs to rx_data[7:0].
REQ-007 SHALL have port rx_ready  input  1  MGT startup done; when low, the input is invalid.
REQ-008 SHALL have port gem_data  output  56  reassembled cluster payload.
REQ-009 SHALL have port overflow_o, bc0_o, resync_o  output  1 each  frame flags.
REQ-010 SHALL have port valid_o  output  1  one-cycle strobe marking a new, error-free frame.
REQ-011 SHALL have port locked_o  output  1  high in the LOCKED state only.
REQ-012 SHALL have port frame_err_o  output  1  one-cycle strobe on any frame error.
REQ-013 SHALL have port err_cnt  output  16  count of frame errors.

Function
REQ-014 SHALL treat a frame as 4 consecutive words (one BX), W0..W3.
REQ-015 SHALL define a good W0 as: rx_isk==2'b01 and rx_data[7:0] is one of K28.5 (0xBC, normal), K28.1 (0x3C, overflow), K28.3 (0x7C, BC0) or K28.7 (0xFC, resync).
REQ-016 SHALL require rx_isk==2'b00 on W1..W3; any other value there is a frame error.
REQ-017 SHALL map the payload as gem_data[55:48]=W0[15:8], [47:32]=W1, [31:16]=W2 and [15:0]=W3.
REQ-018 SHALL derive flags from the W0 K char: overflow_o for K28.1, bc0_o for K28.3, resync_o for K28.7; all flags are 0 for K28.5.
REQ-019 SHALL use a state machine with states UNLOCKED, SYNCING and LOCKED, plus a 2-bit word index.
REQ-020 In UNLOCKED, a good W0 SHALL set the index to 1, set good_cnt to 1 and move to SYNCING; any other word SHALL leave the state unchanged.
REQ-021 In SYNCING, at index 0: a good W0 SHALL increment good_cnt, and good_cnt reaching LOCK_COUNT SHALL move to LOCKED.
REQ-022 In SYNCING, any frame error SHALL return the machine to UNLOCKED with good_cnt cleared.
REQ-023 In LOCKED, each frame error SHALL increment bad_cnt, and reaching UNLOCK_COUNT SHALL move to UNLOCKED.
REQ-024 In LOCKED, an error-free frame SHALL clear bad_cnt.
REQ-025 The index SHALL free-run mod 4 in SYNCING and LOCKED; it SHALL NOT re-align to a stray header.
REQ-026 valid_o SHALL pulse in the cycle after W3 is sampled, only in LOCKED and only for an error-free frame.
REQ-027 gem_data and the flags SHALL update in the same cycle as valid_o and hold until the next valid_o.
REQ-028 A LOCKED frame with an error SHALL NOT assert valid_o; the outputs keep their previous values.
REQ-029 frame_err_o SHALL pulse once per errored frame, in SYNCING or LOCKED, in the cycle after the offending word.
REQ-030 rx_ready low SHALL force UNLOCKED, clear all counters and suppress valid_o, on the next edge.
REQ-031 Simultaneous frame error and UNLOCK_COUNT reached SHALL give the transition and the frame_err_o strobe in the same cycle.

Reset
REQ-032 On reset, the state SHALL be UNLOCKED, the index, good_cnt and bad_cnt SHALL be 0, and all outputs including err_cnt SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; valid_o SHALL NOT be asserted for it.

Configuration
REQ-034 SHALL support macro TRG_LINK_RX_ERR_CNT_EN.
REQ-035 With TRG_LINK_RX_ERR_CNT_EN defined, err_cnt SHALL increment on each frame_err_o and saturate at 0xFFFF.
REQ-036 With TRG_LINK_RX_ERR_CNT_EN undefined, err_cnt SHALL be tied to 0 and no counter logic is generated; all other behaviour is unchanged.

Structure
REQ-037 K-char constants (0xBC, 0x3C, 0x7C, 0xFC) and the state encoding SHALL live in a shared package, trg_link_pkg, for reuse by the transmit side.
REQ-038 Header classification (good W0 and K-char decode to flags) SHALL be one sub-module, trg_link_hdr_decode, which is purely combinational.

Verification
REQ-039 A bench SHALL cover: 4 frames with W0=0x12BC then W1..W3=0x3456,0x789A,0xBCDE, isk 01,00,00,00 -> locked_o high after the 4th header; first valid_o on the 5th frame with gem_data=0x123456789ABCDE and all flags 0.
REQ-040 A bench SHALL cover: while LOCKED, W0 low byte 0x7C -> bc0_o=1 with valid_o; the next frame with 0xBC -> bc0_o=0.
REQ-041 A bench SHALL cover: while LOCKED, isk=2'b10 on W2 for 1 frame -> frame_err_o pulse, no valid_o, err_cnt=1, still LOCKED; the next good frame clears bad_cnt.
REQ-042 A bench SHALL cover: 3 consecutive bad frames -> locked_o low after the 3rd; a re-lock needs 4 good headers.
REQ-043 A bench SHALL cover: rx_ready deasserted mid-frame while LOCKED -> UNLOCKED next cycle, no valid_o; with the macro defined, err_cnt is forced to 0xFFFF and one more error leaves it at 0xFFFF.
REQ-044 A bench SHALL cover: reset pulsed at W1 -> all outputs 0 the next cycle; header search restarts.
